// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the simple-dual-port lane-masked RAM.
//   state_e : controller states (sweep-clear vs. normal operation)
//   lanes() : number of write lanes in a word
package sdp_ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR,
    ST_READY
  } state_e;

  function automatic int unsigned lanes(input int unsigned data_width,
                                        input int unsigned lane_width);
    return data_width / lane_width;
  endfunction

endpackage

// File: rtl/sdp_ram_rd_pipe.sv
// Read-path delay line: STAGES registered stages of data plus valid.
// Data registers only advance with a valid, so the output word holds its
// last value between reads. Valids (and data) clear on synchronous reset.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   valid_i, data_i   : stage-1 read result
//   valid_o, data_o   : delayed result (combinational bypass when STAGES=0)
module sdp_ram_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 28,
  parameter int unsigned STAGES     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  if (STAGES == 0) begin : gen_bypass
    assign valid_o = valid_i;
    assign data_o  = data_i;
  end else begin : gen_stages
    logic [STAGES-1:0]     valid_q;
    logic [DATA_WIDTH-1:0] data_q [STAGES];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= '0;
        for (int i = 0; i < int'(STAGES); i++) begin
          data_q[i] <= '0;
        end
      end else begin
        valid_q[0] <= valid_i;
        if (valid_i) data_q[0] <= data_i;
        for (int i = 1; i < int'(STAGES); i++) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign valid_o = valid_q[STAGES-1];
    assign data_o  = data_q[STAGES-1];
  end

endmodule

// File: rtl/sdp_ram_lane_pipe.sv
// Simple-dual-port RAM with per-lane write enables, a registered read path of
// RD_LATENCY cycles with a valid strobe, write-first forwarding on same-address
// read/write, and an optional post-reset clear sweep.
//   clk, rst               : clock, synchronous active-high reset
//   wr_en/wr_addr/...      : write port, wr_lane_en masks LANE_WIDTH slices
//   rd_en/rd_addr          : read request
//   data_o, data_o_valid   : read result, valid pulses RD_LATENCY cycles later
//   busy                   : clear sweep in progress; requests are ignored
module sdp_ram_lane_pipe
  import sdp_ram_pkg::*;
#(
  parameter int unsigned  ADDR_WIDTH     = 15,
  parameter int unsigned  DATA_WIDTH     = 28,
  parameter int unsigned  LANE_WIDTH     = 7,
  parameter int unsigned  RD_LATENCY     = 2,
  parameter bit           CLEAR_ON_RESET = 1'b1,
  localparam int unsigned LANES          = lanes(DATA_WIDTH, LANE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [LANES-1:0]      wr_lane_en,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_o_valid,
  output logic                  busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % LANE_WIDTH != 0) begin : gen_err_lane
    $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : gen_err_lat
    $error("RD_LATENCY must be in 1..4");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready;

  assign ready = (state_q == ST_READY);
  assign busy  = (state_q == ST_CLEAR);

  // Controller
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_READY;
      end
      ST_READY: ;
      default:  state_d = ST_READY;
    endcase
  end

  // Array write port: the sweep borrows it while clearing
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [LANES-1:0]      mem_wmask;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = data_i;
    mem_wmask = wr_lane_en;
    if (busy) begin
      mem_we    = ~rst;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      mem_wmask = '1;
    end else begin
      mem_we    = wr_en & ~rst;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (mem_wmask[k]) begin
          mem_q[mem_waddr][k*LANE_WIDTH +: LANE_WIDTH] <= mem_wdata[k*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Read with write-first forwarding of enabled lanes on an address match
  logic                  rd_acc;
  logic                  wr_hit;
  logic [DATA_WIDTH-1:0] rd_word;

  assign rd_acc = rd_en & ready & ~rst;
  assign wr_hit = wr_en & ready & (wr_addr == rd_addr);

  always_comb begin
    rd_word = mem_q[rd_addr];
    for (int unsigned k = 0; k < LANES; k++) begin
      if (wr_hit && wr_lane_en[k]) begin
        rd_word[k*LANE_WIDTH +: LANE_WIDTH] = data_i[k*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Stage 1: synchronous array read
  logic                  rd_vld_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_vld_q <= rd_acc;
      if (rd_acc) rd_data_q <= rd_word;
    end
  end

  sdp_ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .STAGES     (RD_LATENCY - 1)
  ) u_rd_pipe (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (rd_vld_q),
    .data_i  (rd_data_q),
    .valid_o (data_o_valid),
    .data_o  (data_o)
  );

endmodule

// File: tb/tb_sdp_ram_lane_pipe.sv
module tb_sdp_ram_lane_pipe;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 28;
  localparam int unsigned ND    = 4;
  localparam int unsigned DEPTH = 16;
  // Instance set: 0 = lat2 clear, 1 = lat1 clear, 2 = lat4 clear, 3 = lat2 no-clear
  localparam int unsigned LAT [ND] = '{2, 1, 4, 2};
  localparam bit          CLR [ND] = '{1'b1, 1'b1, 1'b1, 1'b0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [3:0]    wr_lane_en = '0;
  logic [DW-1:0] data_i = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] dout [ND];
  logic          dval [ND];
  logic          dbusy [ND];

  always #5 clk = ~clk;

  sdp_ram_lane_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(28), .LANE_WIDTH(7), .RD_LATENCY(2),
                      .CLEAR_ON_RESET(1'b1)) u_l2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_en(wr_lane_en),
    .data_i(data_i), .rd_en(rd_en), .rd_addr(rd_addr), .data_o(dout[0]),
    .data_o_valid(dval[0]), .busy(dbusy[0]));
  sdp_ram_lane_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(28), .LANE_WIDTH(7), .RD_LATENCY(1),
                      .CLEAR_ON_RESET(1'b1)) u_l1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_en(wr_lane_en),
    .data_i(data_i), .rd_en(rd_en), .rd_addr(rd_addr), .data_o(dout[1]),
    .data_o_valid(dval[1]), .busy(dbusy[1]));
  sdp_ram_lane_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(28), .LANE_WIDTH(7), .RD_LATENCY(4),
                      .CLEAR_ON_RESET(1'b1)) u_l4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_en(wr_lane_en),
    .data_i(data_i), .rd_en(rd_en), .rd_addr(rd_addr), .data_o(dout[2]),
    .data_o_valid(dval[2]), .busy(dbusy[2]));
  sdp_ram_lane_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(28), .LANE_WIDTH(7), .RD_LATENCY(2),
                      .CLEAR_ON_RESET(1'b0)) u_nc (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_en(wr_lane_en),
    .data_i(data_i), .rd_en(rd_en), .rd_addr(rd_addr), .data_o(dout[3]),
    .data_o_valid(dval[3]), .busy(dbusy[3]));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] lmask(input logic [3:0] le);
    logic [DW-1:0] m;
    for (int k = 0; k < 4; k++) m[k*7 +: 7] = {7{le[k]}};
    return m;
  endfunction

  // ---------------- Behavioural model ----------------
  // Memory image plus a "known bits" mask (no-clear instance starts unknown),
  // and a timeline of future outputs: slot 0 is what shows after this edge.
  logic [DW-1:0] mem   [ND][DEPTH];
  logic [DW-1:0] mem_k [ND][DEPTH];
  int            busy_left [ND];
  logic          fut_v [ND][5];
  logic [DW-1:0] fut_d [ND][5];
  logic [DW-1:0] fut_m [ND][5];
  logic [DW-1:0] last_d [ND];
  logic [DW-1:0] last_m [ND];
  bit            started = 1'b0;

  task automatic model_step();
    logic [DW-1:0] rv, rk, lm;
    lm = lmask(wr_lane_en);
    for (int d = 0; d < int'(ND); d++) begin
      if (rst) begin
        busy_left[d] = CLR[d] ? DEPTH : 0;
        for (int k = 0; k < 5; k++) fut_v[d][k] = 1'b0;
        last_d[d] = '0;
        last_m[d] = '1;
      end else begin
        for (int k = 0; k < 4; k++) begin
          fut_v[d][k] = fut_v[d][k+1];
          fut_d[d][k] = fut_d[d][k+1];
          fut_m[d][k] = fut_m[d][k+1];
        end
        fut_v[d][4] = 1'b0;
        if (busy_left[d] > 0) begin
          mem[d][DEPTH - busy_left[d]]   = '0;
          mem_k[d][DEPTH - busy_left[d]] = '1;
          busy_left[d]--;
        end else begin
          if (rd_en) begin
            rv = mem[d][rd_addr];
            rk = mem_k[d][rd_addr];
            if (wr_en && wr_addr == rd_addr) begin
              rv = (rv & ~lm) | (data_i & lm);
              rk = rk | lm;
            end
            fut_v[d][LAT[d]-1] = 1'b1;
            fut_d[d][LAT[d]-1] = rv;
            fut_m[d][LAT[d]-1] = rk;
          end
          if (wr_en) begin
            mem[d][wr_addr]   = (mem[d][wr_addr] & ~lm) | (data_i & lm);
            mem_k[d][wr_addr] = mem_k[d][wr_addr] | lm;
          end
        end
        if (fut_v[d][0]) begin
          last_d[d] = fut_d[d][0];
          last_m[d] = fut_m[d][0];
        end
      end
    end
    if (rst) started = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < int'(ND); d++) begin
      busy_left[d] = 0;
      last_d[d] = '0;
      last_m[d] = '0;
      for (int k = 0; k < 5; k++) fut_v[d][k] = 1'b0;
      for (int a = 0; a < int'(DEPTH); a++) begin
        mem[d][a]   = '0;
        mem_k[d][a] = '0;
      end
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare every instance against the model each cycle
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int d = 0; d < int'(ND); d++) begin
          chk($sformatf("valid[%0d]", d), 32'(dval[d]), 32'(fut_v[d][0]));
          chk($sformatf("data[%0d]", d), 32'(dout[d] & last_m[d]), 32'(last_d[d] & last_m[d]));
          chk($sformatf("busy[%0d]", d), 32'(dbusy[d]), 32'(busy_left[d] > 0));
        end
      end
    end
  end

  // ---------------- Directed stimulus ----------------
  int            cyc_no = 0;
  int            vcnt [ND] = '{0, 0, 0, 0};
  bit            cap_en = 1'b0;
  bit            nc_busy_seen = 1'b0;
  logic [DW-1:0] cap_q [ND][$];
  int            cap_c [ND][$];

  task automatic step();
    @(negedge clk);
    cyc_no++;
    for (int d = 0; d < int'(ND); d++) begin
      if (dval[d]) begin
        vcnt[d]++;
        if (cap_en) begin
          cap_q[d].push_back(dout[d]);
          cap_c[d].push_back(cyc_no);
        end
      end
    end
    if (started && dbusy[3]) nc_busy_seen = 1'b1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_lane_en = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [3:0] le);
    wr_en = 1'b1;
    wr_addr = 4'(a);
    data_i = d;
    wr_lane_en = le;
  endtask

  task automatic rd(input int a);
    rd_en = 1'b1;
    rd_addr = 4'(a);
  endtask

  initial begin
    int n, v0, v1, v2;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // 1: sweep length, reads ignored while busy, array reads back zero
    n = 0;
    v0 = vcnt[0] + vcnt[1] + vcnt[2];
    while (dbusy[0] && n < 40) begin
      rd(n);
      step();
      n++;
    end
    idle();
    chk("t1_busy_cycles", 32'(n), 32'd16);
    repeat (5) step();
    chk("t1_no_valid_while_busy", 32'(vcnt[0] + vcnt[1] + vcnt[2] - v0), 32'd0);
    v0 = vcnt[0];
    for (int a = 0; a < 16; a++) begin
      rd(a);
      step();
    end
    idle();
    repeat (5) step();
    chk("t1_l2_read_count", 32'(vcnt[0] - v0), 32'd16);

    // 2: full write then read, latency 2 vs 1
    wr(3, 28'h0ABCDEF, 4'hF);
    step();
    idle();
    rd(3);
    step();
    idle();
    chk("t2_l2_not_yet", 32'(dval[0]), 32'd0);
    chk("t2_l1_valid", 32'(dval[1]), 32'd1);
    chk("t2_l1_data", 32'(dout[1]), 32'h0ABCDEF);
    step();
    chk("t2_l2_valid", 32'(dval[0]), 32'd1);
    chk("t2_l2_data", 32'(dout[0]), 32'h0ABCDEF);
    step();
    chk("t2_l2_pulse_end", 32'(dval[0]), 32'd0);
    chk("t2_l2_hold", 32'(dout[0]), 32'h0ABCDEF);

    // 3: lanes 0 and 2 zeroed while reading the same address
    wr(5, 28'hFFFFFFF, 4'hF);
    step();
    wr(5, 28'h0000000, 4'b0101);
    rd(5);
    step();
    idle();
    step();
    chk("t3_fwd_valid", 32'(dval[0]), 32'd1);
    chk("t3_fwd_data", 32'(dout[0]), 32'hFE03F80);
    rd(5);
    step();
    idle();
    step();
    chk("t3_later_data", 32'(dout[0]), 32'hFE03F80);

    // 4: pattern fill then 16 back-to-back reads
    for (int a = 0; a < 16; a++) begin
      wr(a, 28'(a * 'h111), 4'hF);
      step();
    end
    idle();
    for (int d = 0; d < int'(ND); d++) begin
      cap_q[d].delete();
      cap_c[d].delete();
    end
    cap_en = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rd(a);
      step();
    end
    idle();
    repeat (6) step();
    cap_en = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("t4_count[%0d]", d), 32'(cap_q[d].size()), 32'd16);
      if (cap_q[d].size() == 16) begin
        chk($sformatf("t4_consec[%0d]", d), 32'(cap_c[d][15] - cap_c[d][0]), 32'd15);
        for (int i = 0; i < 16; i++) begin
          chk($sformatf("t4_word[%0d][%0d]", d, i), 32'(cap_q[d][i]), 32'(i * 'h111));
        end
      end
    end

    // 5: reset with reads in flight, then reset again mid-sweep
    rd(3);
    step();
    rd(5);
    step();
    idle();
    v2 = vcnt[2];
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (9) step();
    chk("t5_dropped_reads", 32'(vcnt[2] - v2), 32'd0);
    chk("t5_busy_mid", 32'(dbusy[0]), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (dbusy[0] && n < 40) begin
      step();
      n++;
    end
    chk("t5_busy_restart", 32'(n), 32'd16);
    rd(3);
    step();
    rd(15);
    step();
    idle();
    repeat (5) step();

    // 6: no-clear instance is usable right after reset
    v1 = vcnt[3];
    do_reset();
    chk("t6_nc_busy_after_rst", 32'(dbusy[3]), 32'd0);
    wr(7, 28'h1234567, 4'hF);
    step();
    idle();
    rd(7);
    step();
    idle();
    step();
    chk("t6_nc_valid", 32'(dval[3]), 32'd1);
    chk("t6_nc_data", 32'(dout[3]), 32'h1234567);
    chk("t6_nc_valid_count", 32'(vcnt[3] - v1), 32'd1);
    chk("t6_clr_ignored", 32'(dval[0]), 32'd0);
    repeat (20) step();
    chk("t6_nc_never_busy", 32'(nc_busy_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "timeout");
  end

endmodule
